// File: rtl/emergency_preempt.sv
// Conditions the emergency-vehicle sensor into a single all-stop level for both traffic lights.
// Sync + debounce, bounded hold window, and a cooldown so normal cycling always resumes.
module emergency_preempt #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned MIN_HOLD   = 20,
    parameter int unsigned MAX_HOLD   = 200,
    parameter int unsigned COOLDOWN   = 30,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       siren_raw,
    input  logic       manual_req,
    output logic       emergency,
    output logic [2:0] state_o,
    output logic       timeout,
    output logic [7:0] preempt_count
);

    typedef enum logic [2:0] {
        StIdle     = 3'b000,
        StDebounce = 3'b001,
        StHold     = 3'b010,
        StCooldown = 3'b011
    } state_t;

    localparam logic [CNT_W-1:0] DebLast  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] MinLast  = CNT_W'(MIN_HOLD - 1);
    localparam logic [CNT_W-1:0] MaxLast  = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CoolLast = CNT_W'(COOLDOWN - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sync1;
    logic             sync2;
    logic             req;

    // Two-flop synchroniser for the asynchronous sensor.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= siren_raw;
            sync2 <= sync1;
        end
    end

    assign req     = sync2 | manual_req;
    assign state_o = state;

    // emergency/timeout are decoded from the next state so they line up with the state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= StIdle;
            cnt           <= '0;
            emergency     <= 1'b0;
            timeout       <= 1'b0;
            preempt_count <= 8'd0;
        end else begin
            emergency <= 1'b0;
            timeout   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req) begin
                        state <= StDebounce;
                        cnt   <= '0;
                    end
                end
                StDebounce: begin
                    if (!req) begin
                        state <= StIdle;
                        cnt   <= '0;
                    end else if (cnt == DebLast) begin
                        state     <= StHold;
                        cnt       <= '0;
                        emergency <= 1'b1;
                        if (preempt_count != 8'hFF) begin
                            preempt_count <= preempt_count + 8'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StHold: begin
                    if (cnt == MaxLast) begin
                        // A request that drops on this same edge is a normal release.
                        state   <= StCooldown;
                        cnt     <= '0;
                        timeout <= req;
                    end else if (cnt >= MinLast && !req) begin
                        state <= StCooldown;
                        cnt   <= '0;
                    end else begin
                        cnt       <= cnt + 1'b1;
                        emergency <= 1'b1;
                    end
                end
                StCooldown: begin
                    if (cnt == CoolLast) begin
                        state <= req ? StDebounce : StIdle;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_emergency_preempt.sv
// Directed bench for emergency_preempt: latency, glitch rejection, min/max hold,
// cooldown masking and asynchronous reset during a hold.
module tb_emergency_preempt;

    logic       clock;
    logic       reset_n;
    logic       siren_raw;
    logic       manual_req;
    logic       emergency;
    logic [2:0] state_o;
    logic       timeout;
    logic [7:0] preempt_count;

    int vectors;
    int miscompares;
    int hi_cnt;
    int to_cnt;
    logic seen_hi;

    emergency_preempt dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .siren_raw    (siren_raw),
        .manual_req   (manual_req),
        .emergency    (emergency),
        .state_o      (state_o),
        .timeout      (timeout),
        .preempt_count(preempt_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n    = 1'b0;
        siren_raw  = 1'b0;
        manual_req = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        siren_raw   = 1'b0;
        manual_req  = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_emergency", emergency, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_state", state_o, 0);
        chk("rst_count", preempt_count, 0);

        // Sensor held: rise after edge 7, release three edges after the input falls.
        reset_n   = 1'b1;
        siren_raw = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clock);
            if (i == 3) chk("t1_debounce_state", state_o, 3'b001);
            if (i == 6) chk("t1_pre_rise", emergency, 0);
            if (i == 7) begin
                chk("t1_rise", emergency, 1);
                chk("t1_hold_state", state_o, 3'b010);
                chk("t1_count", preempt_count, 1);
            end
            if (i == 40) siren_raw = 1'b0;
            if (i == 42) chk("t1_still_high", emergency, 1);
            if (i == 43) begin
                chk("t1_release", emergency, 0);
                chk("t1_cool_state", state_o, 3'b011);
                chk("t1_no_timeout", timeout, 0);
            end
            if (i == 72) chk("t1_cool_end", state_o, 3'b011);
            if (i == 73) chk("t1_idle", state_o, 3'b000);
        end

        // Three-cycle glitch never reaches HOLD.
        do_reset();
        siren_raw = 1'b1;
        seen_hi   = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            seen_hi = seen_hi | emergency;
            if (i == 3) begin
                chk("t2_debounce", state_o, 3'b001);
                siren_raw = 1'b0;
            end
            if (i == 5) chk("t2_still_deb", state_o, 3'b001);
            if (i == 6) chk("t2_back_idle", state_o, 3'b000);
        end
        chk("t2_never_high", seen_hi, 0);
        chk("t2_count", preempt_count, 0);

        // Short manual request gives exactly MIN_HOLD; a siren pulse mid-cooldown is ignored.
        do_reset();
        manual_req = 1'b1;
        hi_cnt     = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            if (emergency) hi_cnt++;
            if (i == 4) chk("t3_pre_rise", emergency, 0);
            if (i == 5) begin
                chk("t3_rise", emergency, 1);
                manual_req = 1'b0;
            end
            if (i == 24) chk("t3_last_high", emergency, 1);
            if (i == 25) begin
                chk("t3_release", emergency, 0);
                chk("t3_cool_state", state_o, 3'b011);
            end
            if (i == 29) siren_raw = 1'b1;
            if (i == 39) siren_raw = 1'b0;
            if (i == 54) chk("t3_cool_end", state_o, 3'b011);
            if (i == 55) chk("t3_idle", state_o, 3'b000);
            if (i == 60) begin
                chk("t5_idle", state_o, 3'b000);
                chk("t5_count", preempt_count, 1);
            end
        end
        chk("t3_high_cycles", hi_cnt, 20);

        // Stuck sensor: MAX_HOLD then timeout, cooldown, and a second event.
        do_reset();
        siren_raw = 1'b1;
        hi_cnt    = 0;
        to_cnt    = 0;
        for (int i = 1; i <= 245; i++) begin
            @(negedge clock);
            if (emergency && i <= 240) hi_cnt++;
            if (timeout) to_cnt++;
            if (i == 206) chk("t4_last_high", emergency, 1);
            if (i == 207) begin
                chk("t4_drop", emergency, 0);
                chk("t4_timeout", timeout, 1);
                chk("t4_cool_state", state_o, 3'b011);
            end
            if (i == 208) chk("t4_timeout_end", timeout, 0);
            if (i == 236) chk("t4_cool_end", state_o, 3'b011);
            if (i == 237) chk("t4_redebounce", state_o, 3'b001);
            if (i == 240) chk("t4_pre_rise2", emergency, 0);
            if (i == 241) begin
                chk("t4_rise2", emergency, 1);
                chk("t4_count2", preempt_count, 2);
            end
        end
        chk("t4_high_cycles", hi_cnt, 200);
        chk("t4_timeout_pulses", to_cnt, 1);

        // Asynchronous reset in the middle of a hold.
        do_reset();
        manual_req = 1'b1;
        repeat (10) @(negedge clock);
        chk("t6_holding", emergency, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_drop", emergency, 0);
        chk("t6_async_state", state_o, 3'b000);
        chk("t6_async_count", preempt_count, 0);
        manual_req = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("t6_after_state", state_o, 3'b000);
        chk("t6_after_em", emergency, 0);
        chk("t6_after_count", preempt_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
